osc_phase_accumulator: RTL
==========================

# osc_phase_accumulator

Time-multiplexed phase engine for all VOICES×V_OSC oscillator slots, stepping one slot per sCLK_XVXOSC cycle. It owns the slot sequencer and a 32-bit phase accumulator per slot. It adds the per-slot phase increment each frame, then offsets the phase by the 11-bit `modulation` word from the modulation matrix. The result is the sine LUT address, so this stage sits between the modulation matrix and the sine LUT.

## Interface
- VOICES, 8, voices
- V_OSC, 4, oscillators per voice
- V_WIDTH, 3, voice index width
- O_WIDTH, 2, osc index width
- ACC_W, 32, accumulator width
- ADDR_W, 11, sine LUT address width (= modulation width)

Ports:
- sCLK_XVXOSC  in  1  slot clock, one slot per cycle
- reset_reg_N  in  1  reset, asynchronous, active-low
- run  in  1  sequencer enable; low = freeze
- voice_reset  in  VOICES  per-voice key-on pulse; zeroes that voice's phases
- phase_inc  in  ACC_W  increment for slot issued previous cycle (external registered table read)
- modulation  in  signed 11  phase offset for slot issued previous cycle
- cur_vx  out  V_WIDTH  voice index of slot issued this cycle (stage 0)
- cur_ox  out  O_WIDTH  osc index of slot issued this cycle
- frame_start  out  1  high when slot (0,0) is issued
- sine_addr  out  ADDR_W  LUT address (stage 2)
- addr_vx  out  V_WIDTH  voice tag of sine_addr
- addr_ox  out  O_WIDTH  osc tag of sine_addr
- addr_valid  out  1  sine_addr/tags valid

## Operation
- Slot counter s = {vx,ox}: ox increments first; vx increments when ox wraps V_OSC-1→0; (VOICES-1,V_OSC-1)→(0,0). Advances only while run=1.
- Stage 0 (issue): drive cur_vx/cur_ox; frame_start = run && s==0.
- Stage 1 (accumulate, slot s1 = stage-0 slot of previous cycle, only if it was issued with run=1):
  - If pend[s1]: acc[s1] ← phase_inc, pend[s1] cleared.
  - Else: acc[s1] ← acc[s1] + phase_inc, mod 2^ACC_W.
  - acc_new holds the value written.
- Stage 2 (address): sine_addr = acc_new[ACC_W-1 -: ADDR_W] + modulation (two's complement), mod 2^ADDR_W. Tags = s1; addr_valid=1.
- Reset request: voice_reset[v] sets pend[v][0..V_OSC-1]. If a set and a clear hit the same bit in one cycle, the set wins, so the slot is zeroed again next frame.
- run=0: counter, acc, pend holds; no new issue; in-flight stage-1/2 work drains normally. addr_valid then drops to 0 two cycles later. voice_reset is still captured.
- Width: acc unsigned modulo; modulation sign-extended to ADDR_W, no saturation, wrap intended.

## Timing
- Reset (async assert, sync deassert via clock): cur_vx=0, cur_ox=0, frame_start=0, sine_addr=0, addr_vx=0, addr_ox=0, addr_valid=0, all acc=0, all pend=0.
- Latency: slot issued at cycle t → phase_inc/modulation sampled at t+1 → sine_addr valid at t+2.
- Throughput: one slot per cycle; one frame = VOICES×V_OSC cycles.
- Reset mid-frame: pipeline flushed, the next issue after release is slot (0,0).
- voice_reset is level-sampled each cycle; a multi-cycle pulse is equivalent to a single one unless it spans a clear.

## Structure
- Package `osc_phase_pkg`: ACC_W, ADDR_W, and typedef `slot_t` = struct {vx, ox}, plus the slot-increment function.
- Sub-module `phase_acc_ram`: VOICES×V_OSC×ACC_W storage with one read and one write port. Read addressed at stage 0, write at stage 1, with write-to-read bypass for back-to-back same slot (VOICES×V_OSC=1 configs). Pend flags stay in the top level.

## Test plan
- Reset: hold reset_reg_N=0, clock 5 → all outputs 0; release with run=1 → cur slot sequence 0,1,…,31,0; frame_start every 32 cycles.
- Increment: phase_inc=2^21 all slots, modulation=0 → per slot, sine_addr = 1,2,3,… on successive frames; tags match issue slot delayed 2.
- Modulation: phase_inc=0, modulation=-3 → sine_addr=2045 for every slot; modulation=+1023 with acc top=1500 → 475.
- Wrap: preload via phase_inc=0xFFE00000 once, then 2^21 → acc 0xFFE00000→0x00000000, sine_addr 2047→0.
- Voice reset: voice_reset[2] pulse mid-frame → slots (2,0..3) take acc=phase_inc on next pass, other voices continue. Pulse coinciding with the stage-1 clear of (2,3) → (2,3) reset again next frame.
- Stall: run=0 for 10 cycles mid-frame → addr_valid low after 2 cycles, acc unchanged. On resume the sequence continues from the frozen slot.

Source files
------------

// File: rtl/osc_phase_pkg.sv
// Shared constants, slot type and slot sequencing helper for the oscillator phase engine.
package osc_phase_pkg;

  localparam int unsigned VOICES  = 8;
  localparam int unsigned V_OSC   = 4;
  localparam int unsigned V_WIDTH = 3;
  localparam int unsigned O_WIDTH = 2;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned NSLOT   = VOICES * V_OSC;
  localparam int unsigned SLOT_W  = V_WIDTH + O_WIDTH;

  // Slot index; packing {vx, ox} makes the flat slot number vx*V_OSC + ox.
  typedef struct packed {
    logic [V_WIDTH-1:0] vx;
    logic [O_WIDTH-1:0] ox;
  } slot_t;

  // Next slot in issue order: oscillator index first, then voice, wrapping at the frame end.
  function automatic slot_t slot_next(input slot_t s);
    slot_t n;
    n = s;
    if (s.ox == O_WIDTH'(V_OSC - 1)) begin
      n.ox = '0;
      n.vx = (s.vx == V_WIDTH'(VOICES - 1)) ? '0 : s.vx + V_WIDTH'(1);
    end else begin
      n.ox = s.ox + O_WIDTH'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/phase_acc_ram.sv
// Per-slot phase accumulator storage: registered read port, write port, write-to-read bypass.
module phase_acc_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned W     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage update and registered read; a same-cycle write to the read slot is forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/osc_phase_accumulator.sv
// Time-multiplexed phase engine: slot sequencer, per-slot accumulate, modulated LUT address.
module osc_phase_accumulator
  import osc_phase_pkg::*;
(
  input  logic                     sCLK_XVXOSC,
  input  logic                     reset_reg_N,
  input  logic                     run,
  input  logic [VOICES-1:0]        voice_reset,
  input  logic [ACC_W-1:0]         phase_inc,
  input  logic signed [ADDR_W-1:0] modulation,
  output logic [V_WIDTH-1:0]       cur_vx,
  output logic [O_WIDTH-1:0]       cur_ox,
  output logic                     frame_start,
  output logic [ADDR_W-1:0]        sine_addr,
  output logic [V_WIDTH-1:0]       addr_vx,
  output logic [O_WIDTH-1:0]       addr_ox,
  output logic                     addr_valid
);

  slot_t              cur;
  slot_t              s1;
  logic               v1;
  logic [SLOT_W-1:0]  cur_idx;
  logic [SLOT_W-1:0]  s1_idx;
  logic [ACC_W-1:0]   rd;
  logic [ACC_W-1:0]   acc_new;
  logic [ADDR_W-1:0]  mod_u;
  logic [NSLOT-1:0]   pend;
  logic [NSLOT-1:0]   pend_set;
  logic [NSLOT-1:0]   pend_clr;

  assign cur_idx = cur;
  assign s1_idx  = s1;
  assign mod_u   = modulation;
  assign cur_vx  = cur.vx;
  assign cur_ox  = cur.ox;
  // Gated by reset so the output reads 0 while the engine is held in reset.
  assign frame_start = run && reset_reg_N && (cur == '0);

  phase_acc_ram #(
    .DEPTH (NSLOT),
    .AW    (SLOT_W),
    .W     (ACC_W)
  ) u_ram (
    .clk   (sCLK_XVXOSC),
    .rst_n (reset_reg_N),
    .raddr (cur_idx),
    .rdata (rd),
    .we    (v1),
    .waddr (s1_idx),
    .wdata (acc_new)
  );

  // Stage 0: slot sequencer, frozen while run is low.
  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) cur <= '0;
    else if (run)     cur <= slot_next(cur);
  end

  // Stage 1 pipeline register: slot being accumulated and whether it was actually issued.
  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      s1 <= '0;
      v1 <= 1'b0;
    end else begin
      s1 <= cur;
      v1 <= run;
    end
  end

  // Stage 1 datapath: a pending key-on replaces the accumulator with the increment.
  always_comb begin
    acc_new = pend[s1_idx] ? phase_inc : rd + phase_inc;
  end

  // Key-on requests fan out to every oscillator of the voice; the accumulated slot's flag clears.
  always_comb begin
    pend_set = '0;
    for (int unsigned v = 0; v < VOICES; v++)
      for (int unsigned o = 0; o < V_OSC; o++)
        pend_set[v * V_OSC + o] = voice_reset[v];
    pend_clr = v1 ? (NSLOT'(1) << s1_idx) : '0;
  end

  // Pending-reset flags; a set arriving with a clear wins so the slot is zeroed next frame.
  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) pend <= '0;
    else              pend <= (pend & ~pend_clr) | pend_set;
  end

  // Stage 2: LUT address from the accumulator top bits plus the wrapping modulation offset.
  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      sine_addr  <= '0;
      addr_vx    <= '0;
      addr_ox    <= '0;
      addr_valid <= 1'b0;
    end else begin
      addr_valid <= v1;
      if (v1) begin
        sine_addr <= acc_new[ACC_W-1 -: ADDR_W] + mod_u;
        addr_vx   <= s1.vx;
        addr_ox   <= s1.ox;
      end
    end
  end

endmodule
